axi_lite_wr_arbiter: RTL and testbench

AXI_LITE_WR_ARBITER -- requirements
Module: axi_lite_wr_arbiter

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/axi_lite_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_lite_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: default bus widths, write-arbiter FSM states
// and the write-response encodings.
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting
// one position after the pointer (the previous winner) and returns a one-hot
// grant, the winning index and a flag telling whether anyone was granted.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // First requester found at ptr+1, ptr+2, ... (wrapping) wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s = IDX_W'((int'(ptr_i) + i) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// Multi-requester AXI-Lite write master. One write is in flight at a time;
// requesters are served round-robin, each write runs AW and W concurrently,
// then accepts B and reports the response back to the owning requester.
module axi_lite_wr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int         N_REQ  = 4,
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DATA_W = DATA_W_DEF,
    parameter logic [2:0] PROT   = 3'b000,
    localparam int        STRB_W = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*STRB_W-1:0]   req_strb,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          done_valid,
    output logic [1:0]                done_resp,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_W-1:0]         wdata,
    output logic [STRB_W-1:0]         wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   g_q,          g_d;
    logic [IDX_W-1:0]   last_q,       last_d;
    logic [ADDR_W-1:0]  awaddr_q,     awaddr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [STRB_W-1:0]  wstrb_q,      wstrb_d;
    logic               awvalid_q,    awvalid_d;
    logic               wvalid_q,     wvalid_d;
    logic               bready_q,     bready_d;
    logic [N_REQ-1:0]   done_valid_q, done_valid_d;
    logic [1:0]         done_resp_q,  done_resp_d;

    logic [N_REQ-1:0]   arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_any_s;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (last_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    // Next-state and datapath capture; outputs come straight from the registers.
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_d       = last_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = 1'b0;
        done_valid_d = '0;
        done_resp_d  = done_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    g_d       = arb_idx_s;
                    awaddr_d  = req_addr[arb_idx_s*ADDR_W +: ADDR_W];
                    wdata_d   = req_data[arb_idx_s*DATA_W +: DATA_W];
                    wstrb_d   = req_strb[arb_idx_s*STRB_W +: STRB_W];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_XFER;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_XFER: begin
                // Each channel retires on its own handshake; B is only
                // opened once both have retired.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_RESP;
                    bready_d = 1'b1;
                end else begin
                    state_d  = ST_XFER;
                end
            end
            ST_RESP: begin
                if (bready_q && bvalid) begin
                    done_resp_d       = bresp;
                    done_valid_d[g_q] = 1'b1;
                    last_d            = g_q;
                    state_d           = ST_DONE;
                end else begin
                    bready_d          = 1'b1;
                    state_d           = ST_RESP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every valid/pulse immediately.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            last_q       <= IDX_W'(N_REQ - 1);
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= '0;
            done_resp_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_q       <= last_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end

    // The accept pulse is the grant itself, so it must be seen in the grant
    // cycle; it is masked while reset is held.
    assign req_ready  = (state_q == ST_IDLE && !rst_i) ? arb_gnt_s : '0;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;
    assign awaddr     = awaddr_q;
    assign awprot     = PROT;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Directed bench for axi_lite_wr_arbiter: single write, round-robin order,
// slow AW channel, early B, and reset mid-transfer.
module tb_axi_lite_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*SW-1:0]   req_strb;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      done_valid;
    logic [1:0]        done_resp;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] data_tab [N];
    logic [SW-1:0] strb_tab [N];

    axi_lite_wr_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .PROT   (3'b000)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_strb   (req_strb),
        .req_ready  (req_ready),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .awaddr     (awaddr),
        .awprot     (awprot),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait write by requester idx, starting in an IDLE cycle.
    task automatic do_txn(input int idx, input logic [1:0] resp, input bit drop);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        #1;
        chk("grant", req_ready, oh);
        tick();
        if (drop) req_valid = '0;
        chk("xfer_awvalid", awvalid, 1'b1);
        chk("xfer_wvalid", wvalid, 1'b1);
        chk("xfer_awaddr", awaddr, addr_tab[idx]);
        chk("xfer_wdata", wdata, data_tab[idx]);
        chk("xfer_wstrb", wstrb, strb_tab[idx]);
        chk("xfer_ready_low", req_ready, 4'b0000);
        chk("xfer_bready", bready, 1'b0);
        tick();
        chk("resp_awvalid", awvalid, 1'b0);
        chk("resp_wvalid", wvalid, 1'b0);
        chk("resp_bready", bready, 1'b1);
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        chk("done_valid", done_valid, oh);
        chk("done_resp", done_resp, resp);
        chk("done_bready", bready, 1'b0);
        bvalid = 1'b0;
        bresp  = 2'b00;
        tick();
        chk("done_clear", done_valid, 4'b0000);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        addr_tab[0] = 6'h10; data_tab[0] = 32'hDEADBEEF; strb_tab[0] = 4'hF;
        addr_tab[1] = 6'h11; data_tab[1] = 32'h11111111; strb_tab[1] = 4'h3;
        addr_tab[2] = 6'h12; data_tab[2] = 32'h22222222; strb_tab[2] = 4'hC;
        addr_tab[3] = 6'h13; data_tab[3] = 32'h33333333; strb_tab[3] = 4'h1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = addr_tab[i];
            req_data[i*DW +: DW] = data_tab[i];
            req_strb[i*SW +: SW] = strb_tab[i];
        end
        rst_i     = 1'b1;
        req_valid = 4'b0001;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b0;
        bresp     = 2'b00;

        // Reset state, with a request already pending.
        tick();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done", done_valid, 4'b0000);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_awaddr", awaddr, 6'h00);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_awprot", awprot, 3'b000);
        rst_i = 1'b0;

        // Single write from requester 0; valid dropped after grant.
        do_txn(0, 2'b00, 1'b1);

        // Round-robin with all requesters held: 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_txn(k % N, 2'b00, 1'b0);
        end

        // Slow AW: requester 2, awready after 3 cycles of awvalid.
        req_valid = 4'b0100;
        awready   = 1'b0;
        wready    = 1'b1;
        #1;
        chk("slow_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        chk("slow_aw1", awvalid, 1'b1);
        chk("slow_w1", wvalid, 1'b1);
        tick();
        chk("slow_aw2", awvalid, 1'b1);
        chk("slow_w2", wvalid, 1'b0);
        chk("slow_addr2", awaddr, 6'h12);
        chk("slow_bready2", bready, 1'b0);
        tick();
        chk("slow_aw3", awvalid, 1'b1);
        chk("slow_addr3", awaddr, 6'h12);
        chk("slow_bready3", bready, 1'b0);
        awready = 1'b1;
        tick();
        chk("slow_aw4", awvalid, 1'b0);
        chk("slow_bready4", bready, 1'b1);
        bvalid = 1'b1;
        tick();
        chk("slow_done", done_valid, 4'b0100);
        bvalid = 1'b0;
        tick();

        // Early B during XFER is ignored; real B carries SLVERR.
        req_valid = 4'b1000;
        awready   = 1'b0;
        wready    = 1'b0;
        #1;
        chk("early_grant", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000;
        bvalid    = 1'b1;
        bresp     = 2'b10;
        #1;
        chk("early_bready", bready, 1'b0);
        tick();
        chk("early_aw_held", awvalid, 1'b1);
        chk("early_w_held", wvalid, 1'b1);
        chk("early_no_done", done_valid, 4'b0000);
        chk("early_bready2", bready, 1'b0);
        bvalid  = 1'b0;
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        chk("early_resp_bready", bready, 1'b1);
        bvalid = 1'b1;
        bresp  = 2'b10;
        tick();
        chk("early_done", done_valid, 4'b1000);
        chk("early_slverr", done_resp, 2'b10);
        bvalid = 1'b0;
        bresp  = 2'b00;
        tick();

        // Reset mid-XFER, then a normal write from requester 1.
        req_valid = 4'b0001;
        awready   = 1'b0;
        wready    = 1'b0;
        tick();
        req_valid = 4'b0000;
        chk("mid_aw", awvalid, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_aw", awvalid, 1'b0);
        chk("mid_rst_w", wvalid, 1'b0);
        chk("mid_rst_addr", awaddr, 6'h00);
        tick();
        chk("mid_rst_done", done_valid, 4'b0000);
        rst_i   = 1'b0;
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        chk("mid_post_done", done_valid, 4'b0000);
        req_valid = 4'b0010;
        do_txn(1, 2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
